// File: rtl/yblock_cfg_loader.sv
// Host config-word to block shift sequencer; optional bottom-row readback (READBACK_EN).
// Latency: word accepted at edge t -> cbitout at t+1, confclk high STROBE_CYCLES cycles, idle again 3+STROBE_CYCLES edges later.
// Backpressure: in_ready low while a shift is in flight, and (READBACK_EN) while rd_valid holds unread data.
module yblock_cfg_loader #(
   parameter int BLOCKWIDTH    = 8,
   parameter int BLOCKHEIGHT   = 8,
   parameter int CELLBITS      = 2,
   parameter int STROBE_CYCLES = 2
) (
   input  logic                                    clk,
   input  logic                                    reset_n,
   input  logic                                    in_valid,
   output logic                                    in_ready,
   input  logic [BLOCKWIDTH-1:0]                   in_data,
   output logic [BLOCKWIDTH-1:0]                   cbitout,
   output logic                                    confclk,
   input  logic [BLOCKWIDTH-1:0]                   cbitin,
   output logic                                    rd_valid,
   input  logic                                    rd_ready,
   output logic [BLOCKWIDTH-1:0]                   rd_data,
   output logic [$clog2(BLOCKHEIGHT*CELLBITS)-1:0] shift_count,
   output logic                                    frame_done
);

   localparam int SHIFTS = BLOCKHEIGHT * CELLBITS;
   localparam int CNTW   = $clog2(SHIFTS);
   localparam int STRW   = $clog2(STROBE_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } state_t;

   state_t                state, state_n;
   logic [STRW-1:0]       strb_cnt, strb_cnt_n;
   logic [BLOCKWIDTH-1:0] cbit_n;
   logic [CNTW-1:0]       cnt_n;
   logic                  done_n;
   logic                  rdv_n;
   logic [BLOCKWIDTH-1:0] rdd_n;
   logic                  rdy_n;

`ifndef READBACK_EN
   // Readback inputs are intentionally dead in this build.
   logic unused_rb;
   assign unused_rb = ^{cbitin, rd_ready};
`endif

   // Next-state and next-output computation; every output is registered below.
   always_comb begin
      state_n    = state;
      strb_cnt_n = strb_cnt;
      cbit_n     = cbitout;
      cnt_n      = shift_count;
      done_n     = 1'b0;
      rdv_n      = 1'b0;
      rdd_n      = '0;
`ifdef READBACK_EN
      rdv_n = rd_valid;
      rdd_n = rd_data;
      if (rd_valid && rd_ready) begin
         rdv_n = 1'b0;
      end
`endif
      case (state)
         IDLE: begin
            if (in_valid && in_ready) begin
               cbit_n  = in_data;
               state_n = SETUP;
            end
         end
         SETUP: begin
            strb_cnt_n = '0;
            state_n    = STROBE;
         end
         STROBE: begin
            if (strb_cnt == STRW'(STROBE_CYCLES - 1)) begin
               state_n = HOLD;
            end else begin
               strb_cnt_n = strb_cnt + STRW'(1);
            end
         end
         HOLD: begin
            state_n = IDLE;
            if (shift_count == CNTW'(SHIFTS - 1)) begin
               cnt_n  = '0;
               done_n = 1'b1;
            end else begin
               cnt_n = shift_count + CNTW'(1);
            end
`ifdef READBACK_EN
            // The block's outgoing bits have settled by the end of HOLD.
            rdv_n = 1'b1;
            rdd_n = cbitin;
`endif
         end
         default: state_n = IDLE;
      endcase
      // Ready only in IDLE and never while a readback word is pending.
      rdy_n = (state_n == IDLE) && !rdv_n;
   end

   // State and registered outputs; reset drops confclk and abandons any partial shift.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         strb_cnt    <= '0;
         cbitout     <= '0;
         confclk     <= 1'b0;
         in_ready    <= 1'b0;
         rd_valid    <= 1'b0;
         rd_data     <= '0;
         shift_count <= '0;
         frame_done  <= 1'b0;
      end else begin
         state       <= state_n;
         strb_cnt    <= strb_cnt_n;
         cbitout     <= cbit_n;
         confclk     <= (state_n == STROBE);
         in_ready    <= rdy_n;
         rd_valid    <= rdv_n;
         rd_data     <= rdd_n;
         shift_count <= cnt_n;
         frame_done  <= done_n;
      end
   end

endmodule

// File: tb/tb_yblock_cfg_loader.sv
// Directed bench for yblock_cfg_loader with a behavioural 8x8x2 block model for readback.
// Latency: samples 1 time unit after each rising edge; inputs driven at the same point.
// Backpressure: words are offered only when in_ready is seen high; rd_ready driven per test.
module tb_yblock_cfg_loader;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [7:0] cbitout;
   logic       confclk;
   logic [7:0] cbitin;
   logic       rd_valid;
   logic       rd_ready;
   logic [7:0] rd_data;
   logic [3:0] shift_count;
   logic       frame_done;

   logic       use_blk = 1'b0;
   logic [7:0] cbitin_drv = 8'h00;
   logic [7:0] blk_out = 8'h00;
   logic [7:0] blk_sr [16];

   int errors = 0;
   int checks = 0;
   int pulses = 0;
   int fd_cnt = 0;
   logic [7:0] rdq [$];

`ifdef READBACK_EN
   localparam int PERIOD = 6;
`else
   localparam int PERIOD = 5;
`endif

   assign cbitin = use_blk ? blk_out : cbitin_drv;

   always #5 clk = ~clk;

   yblock_cfg_loader #(
      .BLOCKWIDTH(8), .BLOCKHEIGHT(8), .CELLBITS(2), .STROBE_CYCLES(2)
   ) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .cbitout(cbitout), .confclk(confclk), .cbitin(cbitin),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .shift_count(shift_count), .frame_done(frame_done)
   );

   // Block model: each column is a 16-deep shift chain; cbitout is the bit pushed out.
   always @(posedge confclk) begin
      blk_out <= blk_sr[15];
      for (int i = 15; i > 0; i--) blk_sr[i] <= blk_sr[i-1];
      blk_sr[0] <= cbitout;
   end

   always @(posedge confclk) pulses++;

   always @(negedge clk) begin
      if (frame_done) fd_cnt++;
      if (rd_valid && rd_ready) rdq.push_back(rd_data);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!in_ready && n < 20) begin
         step();
         n++;
      end
      chk(tag, in_ready, 1);
   endtask

   task automatic push_word(input logic [7:0] w);
      wait_ready("push_ready");
      in_valid = 1'b1;
      in_data  = w;
      step();
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   // One word with full per-cycle timing profile; rnd scrambles ignored readback inputs.
   task automatic load_word(input string tag, input logic [7:0] w, input bit rnd);
      logic [3:0] c0;
      logic [3:0] c1;
      wait_ready({tag, "_ready"});
      c0 = shift_count;
      c1 = c0 + 4'd1;
      in_valid = 1'b1;
      in_data  = w;
      step();
      in_valid = 1'b0;
      in_data  = ~w;
      for (int s = 0; s < PERIOD; s++) begin
         if (s > 0) step();
         chk($sformatf("%s_confclk_s%0d", tag, s), confclk, (s == 1 || s == 2));
         chk($sformatf("%s_cbitout_s%0d", tag, s), cbitout, w);
         chk($sformatf("%s_inready_s%0d", tag, s), in_ready, (s == PERIOD - 1));
         chk($sformatf("%s_count_s%0d", tag, s), shift_count, (s >= 4) ? c1 : c0);
`ifdef READBACK_EN
         chk($sformatf("%s_rdvalid_s%0d", tag, s), rd_valid, (s == 4));
`else
         chk($sformatf("%s_rdvalid_s%0d", tag, s), rd_valid, 0);
         chk($sformatf("%s_rddata_s%0d", tag, s), rd_data, 0);
`endif
         if (rnd) begin
            cbitin_drv = 8'($urandom);
            rd_ready   = 1'($urandom);
         end
      end
   endtask

   logic [7:0] frame_a [16];
   logic [7:0] frame_b [16];

   initial begin
      int p0;
      int f0;
      int qbase;
      reset_n  = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
`ifdef READBACK_EN
      rd_ready = 1'b1;
`else
      rd_ready = 1'b0;
`endif
      for (int i = 0; i < 16; i++) begin
         blk_sr[i]  = 8'h00;
         frame_a[i] = 8'(8'h13 * i + 8'h07);
         frame_b[i] = 8'(8'hC1 ^ (8'h1D * i));
      end

      // Reset state
      step();
      step();
      chk("rst_confclk", confclk, 0);
      chk("rst_cbitout", cbitout, 0);
      chk("rst_inready", in_ready, 0);
      chk("rst_rdvalid", rd_valid, 0);
      chk("rst_rddata", rd_data, 0);
      chk("rst_count", shift_count, 0);
      chk("rst_fdone", frame_done, 0);
      reset_n = 1'b1;
      step();
      chk("rst_release_inready", in_ready, 1);

      // Single word timing
      load_word("a5", 8'hA5, 1'b0);

      // Reset in the middle of STROBE
      wait_ready("t1_ready");
      in_valid = 1'b1;
      in_data  = 8'h6E;
      step();
      in_valid = 1'b0;
      step();
      chk("t1_in_strobe", confclk, 1);
      reset_n = 1'b0;
      step();
      chk("t1_confclk", confclk, 0);
      chk("t1_cbitout", cbitout, 0);
      chk("t1_count", shift_count, 0);
      chk("t1_inready_in_reset", in_ready, 0);
      step();
      reset_n = 1'b1;
      step();
      chk("t1_inready_after", in_ready, 1);
      chk("t1_confclk_after", confclk, 0);

      // 16 back-to-back words with in_valid held
      p0 = pulses;
      f0 = fd_cnt;
      in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_data = frame_a[i];
         wait_ready($sformatf("t3_ready%0d", i));
         if (i == 15) begin
            chk("t3_count15", shift_count, 15);
            chk("t3_no_early_fdone", fd_cnt - f0, 0);
         end
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      step();
      step();
      chk("t3_fdone_pulse", frame_done, 1);
      chk("t3_count_wrap", shift_count, 0);
      step();
      chk("t3_fdone_drop", frame_done, 0);
      chk("t3_pulses", pulses - p0, 16);
      chk("t3_fdone_count", fd_cnt - f0, 1);

`ifdef READBACK_EN
      // Readback holds off further loads until consumed
      step();
      rd_ready   = 1'b0;
      cbitin_drv = 8'h3C;
      push_word(8'h11);
      step();
      step();
      step();
      step();
      chk("t4_rdvalid", rd_valid, 1);
      chk("t4_rddata", rd_data, 8'h3C);
      chk("t4_inready", in_ready, 0);
      in_valid = 1'b1;
      in_data  = 8'h22;
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("t4_blocked_rdy%0d", k), in_ready, 0);
         chk($sformatf("t4_blocked_clk%0d", k), confclk, 0);
         chk($sformatf("t4_held_rdv%0d", k), rd_valid, 1);
         chk($sformatf("t4_held_rdd%0d", k), rd_data, 8'h3C);
      end
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      chk("t4_rdvalid_clr", rd_valid, 0);
      chk("t4_inready_free", in_ready, 1);
      chk("t4_cbitout_old", cbitout, 8'h11);
      step();
      in_valid = 1'b0;
      chk("t4_accept_rdy", in_ready, 0);
      chk("t4_accept_cbit", cbitout, 8'h22);
      rd_ready = 1'b1;
      for (int k = 0; k < 8; k++) step();

      // End-to-end frame readback through the block model
      use_blk = 1'b1;
      for (int i = 0; i < 16; i++) push_word(frame_a[i]);
      for (int k = 0; k < 8; k++) step();
      qbase = rdq.size();
      for (int i = 0; i < 16; i++) push_word(frame_b[i]);
      for (int k = 0; k < 8; k++) step();
      chk("t6_rd_words", rdq.size() - qbase, 16);
      for (int i = 0; i < 16; i++) begin
         if (qbase + i < rdq.size())
            chk($sformatf("t6_word%0d", i), rdq[qbase + i], frame_a[i]);
         else
            chk($sformatf("t6_word%0d_missing", i), 0, 1);
      end
      chk("t6_loaded_bottom", blk_sr[15], frame_b[0]);
`else
      // Readback inputs toggled randomly must have no effect
      load_word("t5", 8'h5A, 1'b1);
      load_word("t5b", 8'hC3, 1'b1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
